// File: rtl/inst_fetch_buf_pkg.sv
// Core-level constants and the entry type shared by the fetch buffer,
// its storage array and its bus interface.
package inst_fetch_buf_pkg;

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam int          STALL_WIDTH = 6;
  localparam int          STALL_PC    = 0;
  localparam int          IFB_DEPTH   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifb_entry_t;

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Fetch-side and decode-side signals of the instruction fetch buffer.
interface inst_fetch_buf_if
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH
) ();

  localparam int AW = $clog2(DEPTH);

  logic          flush_i;
  logic          inst_valid_i;
  logic [31:0]   inst_i;
  logic [31:0]   pc_i;
  logic          stall_pc_o;
  // Decode handshake: a transfer happens on a rising edge where inst_valid_o
  // and inst_ready_i are both 1; inst_o/pc_o stay stable while valid waits.
  logic          inst_valid_o;
  logic [31:0]   inst_o;
  logic [31:0]   pc_o;
  logic          inst_ready_i;
  logic [AW:0]   count_o;
  logic          overflow_o;

  modport slave (
    input  flush_i, inst_valid_i, inst_i, pc_i, inst_ready_i,
    output stall_pc_o, inst_valid_o, inst_o, pc_o, count_o, overflow_o
  );

  modport master (
    output flush_i, inst_valid_i, inst_i, pc_i, inst_ready_i,
    input  stall_pc_o, inst_valid_o, inst_o, pc_o, count_o, overflow_o
  );

endinterface

// File: rtl/ifb_ram.sv
// DEPTH x 64 register array: one synchronous write port, one async read port.
module ifb_ram
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifb_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifb_entry_t    rdata
);

  ifb_entry_t mem [DEPTH];

  // Contents need no reset: the read side is masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction fetch buffer: in-order queue of {pc, inst} between ifu and
// decode, with early PC-stall, single-cycle flush and sticky overflow flag.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_fetch_buf_if.slave bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_HIGH = (AW+1)'(DEPTH - 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          full;
  logic          head_valid;
  logic          push;
  logic          pop;
  logic          drop;
  ifb_entry_t    wr_entry;
  ifb_entry_t    head;

  assign full       = (count_q == CNT_FULL);
  assign head_valid = (count_q != '0) & ~bus.flush_i;
  assign pop        = head_valid & bus.inst_ready_i;
  // A pop in the same cycle frees the head slot, so a full buffer can still accept.
  assign push       = bus.inst_valid_i & ~bus.flush_i & (~full | pop);
  assign drop       = bus.inst_valid_i & ~bus.flush_i & full & ~pop;

  assign wr_entry.pc   = bus.pc_i;
  assign wr_entry.inst = bus.inst_i;

  ifb_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Stall one entry early: ifu may still deliver one response after stalling.
  assign bus.stall_pc_o   = (count_q >= CNT_HIGH);
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head_valid ? head.inst : INST_NOP;
  assign bus.pc_o         = head_valid ? head.pc   : 32'h0;
  assign bus.count_o      = count_q;
  assign bus.overflow_o   = overflow_q;

endmodule
